// File: rtl/reg_writeback_unit_pkg.sv
// Shared types for the register-file write-back slice.
// Register addressing, data width and the buffered write request.
// Imported by the interface, the load FIFO and the top.
package reg_writeback_unit_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_addr_t;

  // One pending register-file write: destination plus result.
  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // x0 is hard-wired to zero, so it never holds a pending write.
  function automatic logic addr_live(input reg_addr_t a);
    return a != '0;
  endfunction

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Bundle of issue, hazard-query, result and write-port signals.
// master = EX/MEM/decode side, slave = the write-back unit.
// Forwarding signals exist only when WB_BYPASS_EN is defined.
interface reg_writeback_unit_if;
  import reg_writeback_unit_pkg::*;

  logic            iss_valid;
  reg_addr_t       iss_rd;
  reg_addr_t       rs1_addr;
  reg_addr_t       rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_busy;
  logic            exe_valid;
  reg_addr_t       exe_rd;
  logic [XLEN-1:0] exe_data;
  logic            ld_valid;
  logic            ld_ready;
  reg_addr_t       ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            w_enable;
  reg_addr_t       w_addr;
  logic [XLEN-1:0] w_data;
`ifdef WB_BYPASS_EN
  logic            rs1_fwd_valid;
  logic [XLEN-1:0] rs1_fwd_data;
  logic            rs2_fwd_valid;
  logic [XLEN-1:0] rs2_fwd_data;
`endif

  modport master (
    output iss_valid, iss_rd, rs1_addr, rs2_addr,
    output exe_valid, exe_rd, exe_data,
    output ld_valid, ld_rd, ld_data,
`ifdef WB_BYPASS_EN
    input  rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data,
`endif
    input  rs1_busy, rs2_busy, rd_busy, ld_ready,
    input  w_enable, w_addr, w_data
  );

  modport slave (
    input  iss_valid, iss_rd, rs1_addr, rs2_addr,
    input  exe_valid, exe_rd, exe_data,
    input  ld_valid, ld_rd, ld_data,
`ifdef WB_BYPASS_EN
    output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data,
`endif
    output rs1_busy, rs2_busy, rd_busy, ld_ready,
    output w_enable, w_addr, w_data
  );

endinterface

// File: rtl/reg_writeback_unit_wb_result_fifo.sv
// Circular buffer of wb_req_t holding load results until the write port is free.
// Latency: an entry pushed at one edge is visible at the head from the next cycle.
// Backpressure: push_rdy = !full (registered count only, no pop->ready path); DEPTH power of two.
module wb_result_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_vld,
  output logic    push_rdy,
  input  wb_req_t push_dat,
  output logic    pop_vld,
  input  logic    pop_rdy,
  output wb_req_t pop_dat,
  output logic    full,
  output logic    empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  wb_req_t       mem_q [DEPTH];
  wb_req_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign push_rdy = !full;
  assign pop_vld  = !empty;
  assign pop_dat  = mem_q[rd_ptr_q];
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_vld && pop_rdy;

  // Next-state: write at wr_ptr, advance pointers (wrap by power-of-two width), track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointers; reset discards every buffered entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Serialises execute and load results onto the single register-file write port; tracks pending writes.
// Latency: result accepted at edge N appears on w_* after edge N (1 cycle); loads wait >= 1 cycle in the FIFO.
// Backpressure: exe never stalls and wins the port; loads stall via ld_ready = !full. Option: WB_BYPASS_EN.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_writeback_unit_if.slave  bus
);

  wb_req_t         exe_req, ld_req, fifo_head, win_req;
  logic            fifo_push_rdy, fifo_pop_vld, fifo_pop_rdy, fifo_full, fifo_empty;
  logic            win_vld;
  logic            w_enable_d, w_enable_q;
  reg_addr_t       w_addr_d, w_addr_q;
  logic [XLEN-1:0] w_data_d, w_data_q;
  logic [NREG-1:0] pend_d, pend_q;
  logic            rs1_pend, rs2_pend, rs1_inflight, rs2_inflight;

  assign exe_req = '{rd: bus.exe_rd, data: bus.exe_data};
  assign ld_req  = '{rd: bus.ld_rd, data: bus.ld_data};

  // The FIFO only pops when execute leaves the port idle.
  assign fifo_pop_rdy = !bus.exe_valid && !fifo_empty;

  wb_result_fifo #(
    .DEPTH (LD_FIFO_DEPTH)
  ) u_ld_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (bus.ld_valid && fifo_push_rdy),
    .push_rdy (fifo_push_rdy),
    .push_dat (ld_req),
    .pop_vld  (fifo_pop_vld),
    .pop_rdy  (fifo_pop_rdy),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.ld_ready = !fifo_full;

  // Arbitration: execute first, else FIFO head; x0 results are consumed without a write.
  always_comb begin
    win_vld    = bus.exe_valid || fifo_pop_vld;
    win_req    = bus.exe_valid ? exe_req : fifo_head;
    w_enable_d = win_vld && addr_live(win_req.rd);
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    if (w_enable_d) begin
      w_addr_d = win_req.rd;
      w_data_d = win_req.data;
    end
  end

  // Scoreboard: clear on the edge launching the write, then set from issue so a same-edge set wins.
  always_comb begin
    pend_d = pend_q;
    if (w_enable_d) pend_d[win_req.rd] = 1'b0;
    if (bus.iss_valid && addr_live(bus.iss_rd)) pend_d[bus.iss_rd] = 1'b1;
  end

  // Write-port registers and pending mask; reset drops w_enable without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_enable_q <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      pend_q     <= '0;
    end else begin
      w_enable_q <= w_enable_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      pend_q     <= pend_d;
    end
  end

  assign bus.w_enable = w_enable_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_data   = w_data_q;

  // Hazard query terms: still-pending write, and a write sitting on the port this cycle.
  assign rs1_pend     = pend_q[bus.rs1_addr] && addr_live(bus.rs1_addr);
  assign rs2_pend     = pend_q[bus.rs2_addr] && addr_live(bus.rs2_addr);
  assign rs1_inflight = w_enable_q && (w_addr_q == bus.rs1_addr) && addr_live(bus.rs1_addr);
  assign rs2_inflight = w_enable_q && (w_addr_q == bus.rs2_addr) && addr_live(bus.rs2_addr);
  assign bus.rd_busy  = pend_q[bus.iss_rd] && addr_live(bus.iss_rd);

`ifdef WB_BYPASS_EN
  // The in-flight write is forwarded straight to decode, so it no longer stalls.
  assign bus.rs1_fwd_valid = rs1_inflight;
  assign bus.rs1_fwd_data  = w_data_q;
  assign bus.rs2_fwd_valid = rs2_inflight;
  assign bus.rs2_fwd_data  = w_data_q;
  assign bus.rs1_busy      = rs1_pend && !rs1_inflight;
  assign bus.rs2_busy      = rs2_pend && !rs2_inflight;
`else
  // Without forwarding a source stays busy until reg_file has committed the write.
  assign bus.rs1_busy = rs1_pend || rs1_inflight;
  assign bus.rs2_busy = rs2_pend || rs2_inflight;
`endif

endmodule
